// File: rtl/raizing_latch_bank.sv
// raizing_latch_bank: bidirectional command-latch bank between the 68K main CPU
// and the Z80 sound CPU. M2S main-to-sub and S2M sub-to-main latches of DW bits.
// Each latch has a pending flag. Main-to-sub latches also have a sticky overrun flag.
// The sub CPU is interrupted either by a level IRQ or by a timed NMI pulse.

// One latch channel: data register plus pending flag (write wins over read).
module raizing_latch_chan #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] data,
  output logic          pend
);
  // Latch data on write; pend set by write, cleared by read, write wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      pend <= 1'b0;
    end else begin
      if (wr) data <= din;
      if (wr)      pend <= 1'b1;
      else if (rd) pend <= 1'b0;
    end
  end
endmodule

module raizing_latch_bank #(
  parameter int M2S      = 2,
  parameter int S2M      = 2,
  parameter int DW       = 8,
  parameter int IRQ_MODE = 0,
  parameter int NMI_LEN  = 16
) (
  input  logic                                   CLK,
  input  logic                                   RESET,
  input  logic                                   M_WR,
  input  logic [((M2S>1)?$clog2(M2S):1)-1:0]     M_WADDR,
  input  logic [DW-1:0]                          M_DIN,
  input  logic                                   M_RD,
  input  logic [((S2M>1)?$clog2(S2M):1)-1:0]     M_RADDR,
  output logic [DW-1:0]                          M_DOUT,
  input  logic                                   M_OVR_CLR,
  output logic [S2M+M2S+M2S-1:0]                 M_STATUS,
  input  logic                                   S_WR,
  input  logic [((S2M>1)?$clog2(S2M):1)-1:0]     S_WADDR,
  input  logic [DW-1:0]                          S_DIN,
  input  logic                                   S_RD,
  input  logic [((M2S>1)?$clog2(M2S):1)-1:0]     S_RADDR,
  output logic [DW-1:0]                          S_DOUT,
  output logic                                   S_IRQ,
  output logic                                   S_NMI
);
  localparam int MAW = (M2S > 1) ? $clog2(M2S) : 1;
  localparam int SAW = (S2M > 1) ? $clog2(S2M) : 1;
  localparam int CW  = $clog2(NMI_LEN + 1);

  logic [M2S-1:0]         m2s_we, m2s_re, m2s_pend, m2s_ovr;
  logic [S2M-1:0]         s2m_we, s2m_re, s2m_pend;
  logic [M2S-1:0][DW-1:0] m2s_data;
  logic [S2M-1:0][DW-1:0] s2m_data;
  logic [DW-1:0]          s_rdata, m_rdata;

  // Address decode: out-of-range indices match no channel, so writes drop
  // and reads mux out zero without touching any flag.
  always_comb begin
    m2s_we  = '0;
    m2s_re  = '0;
    s_rdata = '0;
    for (int i = 0; i < M2S; i++) begin
      m2s_we[i] = M_WR && (M_WADDR == MAW'(i));
      m2s_re[i] = S_RD && (S_RADDR == MAW'(i));
      if (S_RADDR == MAW'(i)) s_rdata = m2s_data[i];
    end
  end

  // Same decode for the sub-to-main direction.
  always_comb begin
    s2m_we  = '0;
    s2m_re  = '0;
    m_rdata = '0;
    for (int i = 0; i < S2M; i++) begin
      s2m_we[i] = S_WR && (S_WADDR == SAW'(i));
      s2m_re[i] = M_RD && (M_RADDR == SAW'(i));
      if (M_RADDR == SAW'(i)) m_rdata = s2m_data[i];
    end
  end

  for (genvar g = 0; g < M2S; g++) begin : g_m2s
    raizing_latch_chan #(.DW(DW)) u_chan (
      .clk(CLK), .rst(RESET), .wr(m2s_we[g]), .rd(m2s_re[g]),
      .din(M_DIN), .data(m2s_data[g]), .pend(m2s_pend[g])
    );
  end

  for (genvar g = 0; g < S2M; g++) begin : g_s2m
    raizing_latch_chan #(.DW(DW)) u_chan (
      .clk(CLK), .rst(RESET), .wr(s2m_we[g]), .rd(s2m_re[g]),
      .din(S_DIN), .data(s2m_data[g]), .pend(s2m_pend[g])
    );
  end

  // Sticky overrun: a write onto a still-pending latch, unless the sub CPU
  // reads it in the same cycle. A new overrun beats the clear.
  always_ff @(posedge CLK) begin
    if (RESET) m2s_ovr <= '0;
    else       m2s_ovr <= (m2s_we & m2s_pend & ~m2s_re) |
                          (m2s_ovr & {M2S{~M_OVR_CLR}});
  end

  // Registered read ports; the data registers supply pre-write (old) data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      S_DOUT <= '0;
      M_DOUT <= '0;
    end else begin
      if (S_RD) S_DOUT <= s_rdata;
      if (M_RD) M_DOUT <= m_rdata;
    end
  end

  assign M_STATUS = {s2m_pend, m2s_pend, m2s_ovr};

  if (IRQ_MODE == 0) begin : g_irq
    logic irq_q;
    // Level IRQ follows the pending flags one cycle late.
    always_ff @(posedge CLK) begin
      if (RESET) irq_q <= 1'b0;
      else       irq_q <= |m2s_pend;
    end
    assign S_IRQ = irq_q;
    assign S_NMI = 1'b0;
  end else begin : g_nmi
    logic [CW-1:0] nmi_cnt;
    // NMI pulse timer: reload on every valid main write, so back-to-back
    // writes stretch the pulse without a gap.
    always_ff @(posedge CLK) begin
      if (RESET)                nmi_cnt <= '0;
      else if (|m2s_we)         nmi_cnt <= CW'(NMI_LEN);
      else if (nmi_cnt != '0)   nmi_cnt <= nmi_cnt - CW'(1);
    end
    assign S_NMI = (nmi_cnt != '0);
    assign S_IRQ = 1'b0;
  end

endmodule

// File: tb/tb_raizing_latch_bank.sv
// Bench for raizing_latch_bank: two instances share stimulus, one in level-IRQ
// mode (a_*) and one in NMI-pulse mode (b_*), both with 3 M2S and 2 S2M latches.
module tb_raizing_latch_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, m_wr, m_rd, m_ovr_clr, s_wr, s_rd;
  logic [1:0] m_waddr, s_raddr;
  logic       m_raddr, s_waddr;
  logic [7:0] m_din, s_din;
  logic [7:0] a_m_dout, a_s_dout, b_m_dout, b_s_dout, a_status, b_status;
  logic       a_irq, a_nmi, b_irq, b_nmi;

  int errors = 0;
  int checks = 0;
  logic [7:0] s_q[$];
  logic [7:0] m_q[$];
  logic [7:0] exp_v;
  logic       exp_b;

  raizing_latch_bank #(.M2S(3), .S2M(2), .DW(8), .IRQ_MODE(0), .NMI_LEN(16)) u_a (
    .CLK(clk), .RESET(rst), .M_WR(m_wr), .M_WADDR(m_waddr), .M_DIN(m_din),
    .M_RD(m_rd), .M_RADDR(m_raddr), .M_DOUT(a_m_dout), .M_OVR_CLR(m_ovr_clr),
    .M_STATUS(a_status), .S_WR(s_wr), .S_WADDR(s_waddr), .S_DIN(s_din),
    .S_RD(s_rd), .S_RADDR(s_raddr), .S_DOUT(a_s_dout), .S_IRQ(a_irq), .S_NMI(a_nmi)
  );

  raizing_latch_bank #(.M2S(3), .S2M(2), .DW(8), .IRQ_MODE(1), .NMI_LEN(16)) u_b (
    .CLK(clk), .RESET(rst), .M_WR(m_wr), .M_WADDR(m_waddr), .M_DIN(m_din),
    .M_RD(m_rd), .M_RADDR(m_raddr), .M_DOUT(b_m_dout), .M_OVR_CLR(m_ovr_clr),
    .M_STATUS(b_status), .S_WR(s_wr), .S_WADDR(s_waddr), .S_DIN(s_din),
    .S_RD(s_rd), .S_RADDR(s_raddr), .S_DOUT(b_s_dout), .S_IRQ(b_irq), .S_NMI(b_nmi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mwr(input logic [1:0] ch, input logic [7:0] d);
    m_waddr = ch; m_din = d; m_wr = 1'b1;
    tick();
    m_wr = 1'b0;
  endtask

  task automatic swr(input logic ch, input logic [7:0] d);
    s_waddr = ch; s_din = d; s_wr = 1'b1;
    tick();
    s_wr = 1'b0;
  endtask

  task automatic srd(input logic [1:0] ch, input logic [7:0] expect_d);
    s_raddr = ch; s_rd = 1'b1;
    s_q.push_back(expect_d);
    tick();
    s_rd = 1'b0;
  endtask

  task automatic mrd(input logic ch, input logic [7:0] expect_d);
    m_raddr = ch; m_rd = 1'b1;
    m_q.push_back(expect_d);
    tick();
    m_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (a_status !== 8'h00) begin errors++; $display("FAIL reset_status: got %h want 00", a_status); end
    checks++; if ({a_m_dout, a_s_dout} !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h want 0000", {a_m_dout, a_s_dout}); end
    checks++; if ({a_irq, a_nmi, b_irq, b_nmi} !== 4'b0) begin errors++; $display("FAIL reset_int: got %b want 0000", {a_irq, a_nmi, b_irq, b_nmi}); end
  endtask

  task automatic test_basic();
    mwr(1, 8'h5A);
    checks++; if (a_status !== 8'h10) begin errors++; $display("FAIL basic_pend: got %h want 10", a_status); end
    srd(1, 8'h5A);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL basic_sdout: got %h want %h", a_s_dout, exp_v); end
    checks++; if (a_status !== 8'h00) begin errors++; $display("FAIL basic_clr: got %h want 00", a_status); end
  endtask

  task automatic test_overrun();
    mwr(0, 8'h11);
    mwr(0, 8'h22);
    checks++; if (a_status !== 8'h09) begin errors++; $display("FAIL ovr_set: got %h want 09", a_status); end
    srd(0, 8'h22);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL ovr_sdout: got %h want %h", a_s_dout, exp_v); end
    checks++; if (a_status !== 8'h01) begin errors++; $display("FAIL ovr_sticky: got %h want 01", a_status); end
    m_ovr_clr = 1'b1; tick(); m_ovr_clr = 1'b0;
    checks++; if (a_status !== 8'h00) begin errors++; $display("FAIL ovr_clr: got %h want 00", a_status); end
    mwr(0, 8'h55);
    m_ovr_clr = 1'b1;
    mwr(0, 8'h66);
    checks++; if (a_status !== 8'h09) begin errors++; $display("FAIL ovr_beats_clr: got %h want 09", a_status); end
    srd(0, 8'h66);
    m_ovr_clr = 1'b0;
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL ovr_sdout2: got %h want %h", a_s_dout, exp_v); end
    checks++; if (a_status !== 8'h00) begin errors++; $display("FAIL ovr_clr2: got %h want 00", a_status); end
  endtask

  task automatic test_same_cycle();
    mwr(0, 8'h44);
    s_raddr = 2'd0; s_rd = 1'b1;
    s_q.push_back(8'h44);
    mwr(0, 8'h33);
    s_rd = 1'b0;
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL same_old_data: got %h want %h", a_s_dout, exp_v); end
    checks++; if (a_status !== 8'h08) begin errors++; $display("FAIL same_pend: got %h want 08", a_status); end
    srd(0, 8'h33);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL same_new_data: got %h want %h", a_s_dout, exp_v); end
  endtask

  task automatic test_s2m();
    swr(1, 8'hA7);
    checks++; if (a_status !== 8'h80) begin errors++; $display("FAIL s2m_pend: got %h want 80", a_status); end
    mrd(1, 8'hA7);
    exp_v = m_q.pop_front();
    checks++; if (a_m_dout !== exp_v) begin errors++; $display("FAIL s2m_mdout: got %h want %h", a_m_dout, exp_v); end
    swr(0, 8'h01);
    swr(0, 8'h02);
    checks++; if (a_status !== 8'h40) begin errors++; $display("FAIL s2m_no_ovr: got %h want 40", a_status); end
    mrd(0, 8'h02);
    exp_v = m_q.pop_front();
    checks++; if (a_m_dout !== exp_v) begin errors++; $display("FAIL s2m_mdout2: got %h want %h", a_m_dout, exp_v); end
    checks++; if (a_status !== 8'h00) begin errors++; $display("FAIL s2m_clr: got %h want 00", a_status); end
  endtask

  task automatic test_nmi();
    repeat (20) tick();
    mwr(0, 8'h01);
    for (int k = 1; k <= 28; k++) begin
      exp_b = (k <= 26);
      checks++; if (b_nmi !== exp_b) begin errors++; $display("FAIL nmi_cycle%0d: got %b want %b", k, b_nmi, exp_b); end
      if (k == 10) mwr(1, 8'h02);
      else         tick();
    end
    checks++; if (a_nmi !== 1'b0) begin errors++; $display("FAIL nmi_mode0: got %b want 0", a_nmi); end
    srd(0, 8'h01);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL nmi_rd0: got %h want %h", a_s_dout, exp_v); end
    srd(1, 8'h02);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL nmi_rd1: got %h want %h", a_s_dout, exp_v); end
  endtask

  task automatic test_irq();
    repeat (20) tick();
    mwr(3, 8'hCC);
    checks++; if (a_status !== 8'h00) begin errors++; $display("FAIL oor_write: got %h want 00", a_status); end
    checks++; if (b_nmi !== 1'b0) begin errors++; $display("FAIL oor_nmi: got %b want 0", b_nmi); end
    tick();
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL oor_irq: got %b want 0", a_irq); end
    mwr(0, 8'hAA);
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL irq_delay: got %b want 0", a_irq); end
    tick();
    checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", a_irq); end
    mwr(2, 8'hBB);
    srd(0, 8'hAA);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL irq_rd0: got %h want %h", a_s_dout, exp_v); end
    tick();
    checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", a_irq); end
    srd(2, 8'hBB);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL irq_rd2: got %h want %h", a_s_dout, exp_v); end
    checks++; if (a_irq !== 1'b1) begin errors++; $display("FAIL irq_lag: got %b want 1", a_irq); end
    tick();
    checks++; if (a_irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b want 0", a_irq); end
    mwr(1, 8'h77);
    srd(3, 8'h00);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL oor_read: got %h want %h", a_s_dout, exp_v); end
    checks++; if (a_status !== 8'h10) begin errors++; $display("FAIL oor_read_flags: got %h want 10", a_status); end
    srd(1, 8'h77);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL oor_rd1: got %h want %h", a_s_dout, exp_v); end
  endtask

  task automatic test_reset_mid();
    mwr(1, 8'h3C);
    srd(1, 8'h3C);
    exp_v = s_q.pop_front();
    checks++; if (b_s_dout !== exp_v) begin errors++; $display("FAIL rm_sdout: got %h want %h", b_s_dout, exp_v); end
    swr(0, 8'hC3);
    swr(1, 8'h99);
    mrd(0, 8'hC3);
    exp_v = m_q.pop_front();
    checks++; if (b_m_dout !== exp_v) begin errors++; $display("FAIL rm_mdout: got %h want %h", b_m_dout, exp_v); end
    mwr(0, 8'h12);
    tick(); tick();
    checks++; if ({a_irq, b_nmi} !== 2'b11) begin errors++; $display("FAIL rm_pre: got %b want 11", {a_irq, b_nmi}); end
    rst = 1'b1; m_wr = 1'b1; m_waddr = 2'd0; m_din = 8'hEE; s_wr = 1'b1; s_waddr = 1'b0; s_din = 8'hEE;
    tick();
    checks++; if ({a_status, b_status} !== 16'h0) begin errors++; $display("FAIL rm_status: got %h want 0000", {a_status, b_status}); end
    checks++; if ({a_m_dout, a_s_dout, b_m_dout, b_s_dout} !== 32'h0) begin errors++; $display("FAIL rm_dout: got %h want 0", {a_m_dout, a_s_dout, b_m_dout, b_s_dout}); end
    checks++; if ({a_irq, a_nmi, b_irq, b_nmi} !== 4'b0) begin errors++; $display("FAIL rm_int: got %b want 0000", {a_irq, a_nmi, b_irq, b_nmi}); end
    rst = 1'b0; m_wr = 1'b0; s_wr = 1'b0;
    tick();
    checks++; if ({a_status, b_nmi} !== 9'h0) begin errors++; $display("FAIL rm_ignored: got %h want 000", {a_status, b_nmi}); end
    srd(0, 8'h00);
    exp_v = s_q.pop_front();
    checks++; if (a_s_dout !== exp_v) begin errors++; $display("FAIL rm_data: got %h want %h", a_s_dout, exp_v); end
  endtask

  initial begin
    rst = 1'b1; m_wr = 1'b0; m_rd = 1'b0; m_ovr_clr = 1'b0; s_wr = 1'b0; s_rd = 1'b0;
    m_waddr = '0; s_raddr = '0; m_raddr = 1'b0; s_waddr = 1'b0; m_din = '0; s_din = '0;
    test_reset();
    test_basic();
    test_overrun();
    test_same_cycle();
    test_s2m();
    test_nmi();
    test_irq();
    test_reset_mid();
    checks++; if (s_q.size() + m_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d want 0", s_q.size() + m_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
